// File: rtl/alu_result_tx_sequencer_pkg.sv
// rtl/alu_result_tx_sequencer_pkg.sv - shared constants and state encoding for the ALU result TX sequencer
package alu_result_tx_sequencer_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'd48;
  localparam logic [7:0] DEF_PREFIX  = 8'd61;
  localparam logic [7:0] DEF_TERM    = 8'd10;

  // Receiver command codes ('f', 'r', 'o', 'd')
  localparam logic [7:0] CMD_F = 8'h66;
  localparam logic [7:0] CMD_R = 8'h72;
  localparam logic [7:0] CMD_O = 8'h6f;
  localparam logic [7:0] CMD_D = 8'h64;

  localparam int FRAME_LEN = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/alu_result_tx_sequencer_bin_to_ascii3.sv
// rtl/alu_result_tx_sequencer_bin_to_ascii3.sv - combinational 8-bit unsigned to three ASCII decimal digits
module bin_to_ascii3
  import alu_result_tx_sequencer_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] hundreds,
  output logic [7:0] tens,
  output logic [7:0] units
);

  logic [7:0] h_dig, t_dig, u_dig;

  always_comb begin
    h_dig = value / 8'd100;
    t_dig = (value / 8'd10) % 8'd10;
    u_dig = value % 8'd10;
  end

  assign hundreds = ASCII_ZERO + h_dig;
  assign tens     = ASCII_ZERO + t_dig;
  assign units    = ASCII_ZERO + u_dig;

endmodule

// File: rtl/alu_result_tx_sequencer.sv
// rtl/alu_result_tx_sequencer.sv - sends one ALU result as "<PREFIX>ddd<TERM>" through the UART TX byte handshake
module alu_result_tx_sequencer
  import alu_result_tx_sequencer_pkg::*;
#(
  parameter int         DBIT    = 8,
  parameter logic [7:0] PREFIX  = DEF_PREFIX,
  parameter logic [7:0] TERM    = DEF_TERM,
  parameter int         TIMEOUT = 200000,
  parameter int         TW      = 18
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [DBIT-1:0] result,
  input  logic            tx_done_tick,
  output logic            tx_start,
  output logic [7:0]      tx_din,
  output logic            busy,
  output logic            done_tick,
  output logic            drop_tick,
  output logic            timeout_tick
);

  localparam logic [2:0]    LAST_IDX = 3'(FRAME_LEN - 1);
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t          state, state_n;
  logic [DBIT-1:0] hold;
  logic [2:0]      idx;
  logic [TW-1:0]   cnt;
  logic [7:0]      dig_h, dig_t, dig_u;
  logic [7:0]      frame_byte;

  bin_to_ascii3 u_digits (
    .value    (8'(hold)),
    .hundreds (dig_h),
    .tens     (dig_t),
    .units    (dig_u)
  );

  always_comb begin
    case (idx)
      3'd0:    frame_byte = PREFIX;
      3'd1:    frame_byte = dig_h;
      3'd2:    frame_byte = dig_t;
      3'd3:    frame_byte = dig_u;
      default: frame_byte = TERM;
    endcase
  end

  // Outputs are decoded from state so reset drops them without waiting for a clock
  always_comb begin
    state_n      = state;
    tx_start     = 1'b0;
    done_tick    = 1'b0;
    timeout_tick = 1'b0;
    drop_tick    = wr && (state != S_IDLE);
    case (state)
      S_IDLE: if (wr) state_n = S_LOAD;
      S_LOAD: state_n = S_SEND;
      S_SEND: begin
        tx_start = 1'b1;
        state_n  = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_tick) begin
          if (idx == LAST_IDX) begin
            done_tick = 1'b1;
            state_n   = S_IDLE;
          end else begin
            state_n = S_LOAD;
          end
        end else if (cnt == CNT_LAST) begin
          timeout_tick = 1'b1;
          state_n      = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      hold   <= '0;
      idx    <= '0;
      cnt    <= '0;
      tx_din <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (wr) begin
          hold <= result;
          idx  <= '0;
        end
        S_LOAD: tx_din <= frame_byte;
        S_SEND: cnt <= '0;
        S_WAIT: begin
          if (tx_done_tick) begin
            if (idx != LAST_IDX) idx <= idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_tx_sequencer.sv
// tb/tb_alu_result_tx_sequencer.sv - self-checking bench with a TX-core responder and an arithmetic frame model
module tb_alu_result_tx_sequencer;

  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] result = 8'd0;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] tx_din;
  logic       busy, done_tick, drop_tick, timeout_tick;

  int total = 0;
  int bad = 0;

  logic [7:0] cap[$];
  int done_cnt = 0, drop_cnt = 0, to_cnt = 0;
  int base, base_done, base_drop;

  int resp_en = 1, resp_delay = 10, resp_same = 0;

  alu_result_tx_sequencer #(.TIMEOUT(TMO), .TW(18)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .result       (result),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .busy         (busy),
    .done_tick    (done_tick),
    .drop_tick    (drop_tick),
    .timeout_tick (timeout_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start) cap.push_back(tx_din);
    if (done_tick) done_cnt++;
    if (drop_tick) drop_cnt++;
    if (timeout_tick) to_cnt++;
  end

  // TX core model: answers each tx_start with tx_done_tick resp_delay cycles later
  initial begin
    int cnt;
    cnt = -1;
    tx_done_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_done_tick = 1'b0;
      if (!reset) cnt = -1;
      else if (cnt == 0) begin
        tx_done_tick = 1'b1;
        cnt = -1;
      end else if (cnt > 0) cnt--;
      if (reset && tx_start && resp_en != 0) begin
        cnt = resp_delay - 1;
        if (resp_same != 0) tx_done_tick = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] v);
    base      = cap.size();
    base_done = done_cnt;
    base_drop = drop_cnt;
    result = v;
    wr = 1'b1;
    step();
    chk("lat_load_no_start", 32'(tx_start), 32'd0);
    chk("busy_after_wr", 32'(busy), 32'd1);
    wr = 1'b0;
    step();
    chk("lat_first_start", 32'(tx_start), 32'd1);
  endtask

  task automatic wait_done_tick();
    bit seen;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (done_tick) begin
        seen = 1;
        break;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_frame(input logic [7:0] v);
    logic [7:0] exp_b[5];
    int n;
    exp_b[0] = 8'd61;
    exp_b[1] = 8'(48 + v / 100);
    exp_b[2] = 8'(48 + (v / 10) % 10);
    exp_b[3] = 8'(48 + v % 10);
    exp_b[4] = 8'd10;
    n = cap.size() - base;
    chk("frame_len", 32'(n), 32'd5);
    for (int i = 0; i < 5; i++)
      if (base + i < cap.size()) chk($sformatf("byte%0d_of_%0d", i, v), 32'(cap[base + i]), 32'(exp_b[i]));
    chk("done_count", 32'(done_cnt - base_done), 32'd1);
  endtask

  initial begin
    logic [7:0] v;
    int k;

    // reset state
    repeat (3) step();
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_din", 32'(tx_din), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ticks", 32'({done_tick, drop_tick, timeout_tick}), 32'd0);
    reset = 1'b1;
    step();

    // 1: 205 with 10-cycle TX latency
    start_frame(8'd205);
    wait_done_tick();
    step();
    chk("idle_after_205", 32'(busy), 32'd0);
    check_frame(8'd205);

    // 2: back-to-back 0 then 255
    start_frame(8'd0);
    wait_done_tick();
    step();
    check_frame(8'd0);
    start_frame(8'd255);
    wait_done_tick();
    step();
    check_frame(8'd255);

    // 3: wr during the tens byte is dropped
    start_frame(8'd18);
    k = 0;
    while (!((cap.size() - base) == 3 && !tx_start) && k < 200) begin
      step();
      k++;
    end
    result = 8'd99;
    wr = 1'b1;
    #1;
    chk("drop_tick_pulse", 32'(drop_tick), 32'd1);
    step();
    wr = 1'b0;
    wait_done_tick();
    step();
    check_frame(8'd18);
    chk("drop_count", 32'(drop_cnt - base_drop), 32'd1);
    repeat (6) step();
    chk("no_second_frame", 32'(cap.size() - base), 32'd5);

    // 4: timeout after TMO wait cycles, then a fresh frame
    resp_en = 0;
    start_frame(8'd123);
    for (k = 1; k <= 200; k++) begin
      step();
      if (timeout_tick) break;
    end
    chk("timeout_cycles", 32'(k), 32'(TMO));
    step();
    chk("idle_after_timeout", 32'(busy), 32'd0);
    repeat (5) step();
    chk("no_bytes_after_timeout", 32'(cap.size() - base), 32'd1);
    chk("timeout_count", 32'(to_cnt), 32'd1);
    resp_en = 1;
    resp_delay = 3;
    start_frame(8'd7);
    wait_done_tick();
    step();
    check_frame(8'd7);

    // 5: reset during the SEND of the third byte
    start_frame(8'd142);
    k = 0;
    while (!(tx_start && (cap.size() - base) == 2) && k < 200) begin
      step();
      k++;
    end
    base_done = done_cnt;
    reset = 1'b0;
    #1;
    chk("async_rst_tx_start", 32'(tx_start), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done_tick), 32'd0);
    step();
    reset = 1'b1;
    repeat (20) step();
    chk("no_bytes_after_reset", 32'(cap.size() - base), 32'd2);
    chk("no_done_after_reset", 32'(done_cnt - base_done), 32'd0);
    v = 8'($urandom_range(0, 255));
    start_frame(v);
    wait_done_tick();
    step();
    check_frame(v);

    // 6: tx_done_tick coinciding with tx_start is ignored
    resp_same = 1;
    resp_delay = 4;
    start_frame(8'd64);
    resp_same = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("same_cycle_tick_ignored", 32'({busy, tx_start}), 32'b10);
    end
    wait_done_tick();
    step();
    check_frame(8'd64);

    // wr coinciding with done_tick is dropped
    start_frame(8'd31);
    wait_done_tick();
    result = 8'd200;
    wr = 1'b1;
    #1;
    chk("drop_on_done", 32'(drop_tick), 32'd1);
    step();
    wr = 1'b0;
    chk("idle_after_done_drop", 32'(busy), 32'd0);
    repeat (4) step();
    check_frame(8'd31);

    // randomized frames against the arithmetic model
    for (int r = 0; r < 6; r++) begin
      v = 8'($urandom_range(0, 255));
      resp_delay = int'($urandom_range(1, 8));
      start_frame(v);
      wait_done_tick();
      step();
      check_frame(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_tx_sequencer.md
Name: alu_result_tx_sequencer

Overview:
Sequences the UART transmitter to return one ALU result to the host as a fixed ASCII frame: prefix, three decimal digits, terminator.
Sits between the command receiver/ALU pair and the UART TX core. Starts on the receiver's one-cycle `wr` pulse.
Owns the TX byte handshake (`tx_start` / `tx_done_tick`), drops requests while busy, and aborts a frame that stalls.

Parameters:
DBIT, 8, ALU result width; the decimal path supports values 0..255 only.
PREFIX, 61, ASCII prefix byte ('=').
TERM, 10, ASCII terminator byte (LF).
TIMEOUT, 200000, clk cycles to wait for `tx_done_tick` before abort; must be ≥ 1.
TW, 18, width of the timeout counter; 2^TW > TIMEOUT.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
wr  in  1  one-cycle request to send the current `result`.
result  in  DBIT  ALU result, unsigned; sampled only on an accepted `wr`.
tx_done_tick  in  1  one-cycle pulse from the TX core when a byte has finished.
tx_start  out  1  one-cycle pulse to the TX core to send `tx_din`.
tx_din  out  8  byte to transmit; registered.
busy  out  1  high from the cycle after an accepted `wr` until the return to IDLE.
done_tick  out  1  one-cycle pulse after the TERM byte completes.
drop_tick  out  1  one-cycle pulse when `wr` arrives while busy.
timeout_tick  out  1  one-cycle pulse when a frame is aborted on timeout.

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; `tx_din`=0; hold register, index and timeout counter cleared.
- Frame: 5 bytes in fixed order, index 0..4 = PREFIX, hundreds, tens, units, TERM.
- Digit encoding: 48 + digit; leading zeros are always sent (e.g. 7 -> "007").
- Digits are computed from the hold register. The conversion (result/100, (result/10)%10, result%10) may be combinational.
- IDLE:
  - `wr`=1 -> capture `result` into the hold register, index=0, go LOAD.
  - `busy` goes 1 on the next cycle.
- LOAD (1 cycle):
  - `tx_din` <= byte[index].
  - Go SEND.
- SEND (1 cycle):
  - `tx_start`=1; `tx_din` is already stable.
  - Clear the timeout counter and go WAIT.
  - Latency from `wr` to the first `tx_start` is 2 cycles (LOAD, then SEND).
- WAIT:
  - `tx_start`=0 and `tx_din` is held.
  - On `tx_done_tick`: if index==4, pulse `done_tick` and go IDLE; otherwise index++ and go LOAD.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no tick: pulse `timeout_tick`, go IDLE, no further bytes.
- `tx_done_tick` outside WAIT (including the SEND cycle itself) is ignored.
- `wr` in any state other than IDLE:
  - `drop_tick`=1 that cycle.
  - The hold register and the frame in progress are unchanged.
- `wr` on the same cycle as the return to IDLE (e.g. with `done_tick` or `timeout_tick`): dropped; the block accepts `wr` only while in IDLE.
- `busy`=0 only in IDLE. The receiver must not depend on `busy` for the first cycle after `wr`.
- Reset mid-frame:
  - Immediate IDLE; `tx_start` deasserts asynchronously.
  - The remaining bytes are never sent and `done_tick` is not pulsed.
- Exactly one `tx_start` per byte. There is never a `tx_start` while WAIT is pending.
- Width rule: the hold register is DBIT bits; the digit path assumes DBIT ≤ 8, so values above 255 are out of scope.

Decomposition:
- Shared package:
  - ASCII constants: ASCII_ZERO=48, default PREFIX and TERM, and the receiver command codes 'f', 'r', 'o', 'd'.
  - State localparam encoding: IDLE, LOAD, SEND, WAIT (2 bits).
  - FRAME_LEN=5.
- Sub-module `bin_to_ascii3`: combinational, 8-bit unsigned in, three 8-bit ASCII digit bytes out. It is reused by any future debug echo path.
- The FSM, index counter and timeout counter stay in `alu_result_tx_sequencer`.

Test Plan:
1. result=205, `wr` pulse; TX model answers each `tx_start` with `tx_done_tick` 10 cycles later -> `tx_din` sequence 61,50,48,53,10; first `tx_start` 2 cycles after `wr`; `done_tick` once; `busy` 0 afterwards.
2. result=0, then result=255 as back-to-back frames (second `wr` sent the cycle after `done_tick`) -> bytes 61,48,48,48,10 then 61,50,53,53,10.
3. result=18, `wr`; pulse `wr` again with result=99 during the tens byte -> `drop_tick` pulses once; the frame is still 61,48,49,56,10 and no second frame follows.
4. TIMEOUT=50, withhold `tx_done_tick` after the first `tx_start` -> `timeout_tick` pulses after 50 WAIT cycles, state IDLE, no further `tx_start`; a new `wr` with 7 then sends 61,48,48,55,10.
5. Assert reset=0 for 1 cycle mid-frame (after 2 bytes) -> `tx_start`, `busy` and `done_tick` all go 0 immediately; no further bytes; the next `wr` starts a fresh frame from PREFIX.
6. `tx_done_tick` asserted in the same cycle as `tx_start` -> it is ignored, the block stays in WAIT, and the index advances only on the later tick.
